jb_redirect_ctrl: RTL and testbench

- Sequences control-flow redirects produced by the EX-stage jump/branch target adder.
- Decides when a resolved branch or jump redirects fetch, latches the target, and holds the request until the fetch stage accepts it.
- Squashes wrong-path instructions and diverts misaligned targets to a trap vector.
- Sits between the EX stage (opcode, compare result, JB target) and the IF PC-select logic.

---
 rtl/jb_redirect_ctrl_if.sv | 24 ++
 rtl/jb_redirect_ctrl.sv | 70 +++++++
 tb/tb_jb_redirect_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/jb_redirect_ctrl_if.sv
// jb_redirect_ctrl_if: EX/IF-facing signal bundle for jb_redirect_ctrl
interface jb_redirect_ctrl_if;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic        ex_br_taken;
  logic [31:0] jb_target;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        misalign_trap;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_taken;
  logic [31:0] cnt_jump;
  modport master (
    output ex_valid, ex_opcode, ex_br_taken, jb_target, if_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, misalign_trap, cnt_branch, cnt_taken, cnt_jump
  );
  modport slave (
    input  ex_valid, ex_opcode, ex_br_taken, jb_target, if_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, misalign_trap, cnt_branch, cnt_taken, cnt_jump
  );
endinterface

// File: rtl/jb_redirect_ctrl.sv
// jb_redirect_ctrl: sequences EX jump/branch redirects to fetch; define JB_PERF_CNT_EN for perf counters
module jb_redirect_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input logic clk,
  input logic rst_n,
  jb_redirect_ctrl_if.slave bus
);
  localparam logic [4:0] OP_BR = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [31:0] tgt_q;
  logic rv_q, mis_q, idle, br, jmp, take;
  always_comb begin
    idle = state == IDLE;
    br   = idle & bus.ex_valid & (bus.ex_opcode == OP_BR);
    jmp  = idle & bus.ex_valid & (bus.ex_opcode == OP_JAL | bus.ex_opcode == OP_JALR);
    take = jmp | br & bus.ex_br_taken;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tgt_q <= '0;
      rv_q  <= 1'b0;
      mis_q <= 1'b0;
    end else
      case (state)
        IDLE: if (take) begin
          state <= ISSUE;
          tgt_q <= bus.jb_target[1] ? TRAP_VEC : bus.jb_target;
          rv_q  <= 1'b1;
          mis_q <= bus.jb_target[1];
        end
        ISSUE: begin
          state <= bus.if_ready ? IDLE : WAIT;
          rv_q  <= !bus.if_ready;
          mis_q <= 1'b0;
        end
        WAIT: if (bus.if_ready) begin
          state <= IDLE;
          rv_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = tgt_q;
  assign bus.misalign_trap  = mis_q;
  assign bus.flush_if       = take | rv_q;
  assign bus.flush_id       = take | rv_q;
`ifdef JB_PERF_CNT_EN
  logic [31:0] cb_q, ct_q, cj_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cb_q <= '0;
      ct_q <= '0;
      cj_q <= '0;
    end else begin
      cb_q <= cb_q + {31'd0, br};
      ct_q <= ct_q + {31'd0, br & bus.ex_br_taken};
      cj_q <= cj_q + {31'd0, jmp};
    end
  assign bus.cnt_branch = cb_q;
  assign bus.cnt_taken  = ct_q;
  assign bus.cnt_jump   = cj_q;
`else
  assign bus.cnt_branch = '0;
  assign bus.cnt_taken  = '0;
  assign bus.cnt_jump   = '0;
`endif
endmodule

// File: tb/tb_jb_redirect_ctrl.sv
// tb_jb_redirect_ctrl: scoreboard bench for jb_redirect_ctrl, counters checked when JB_PERF_CNT_EN is defined
module tb_jb_redirect_ctrl;
  localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001, OPR = 5'b01100;
  typedef struct {logic [31:0] pc; logic trap; int len;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t cur;
  logic active = 1'b0;
  int n = 0;
  logic [31:0] mb = '0, mt = '0, mj = '0;
  jb_redirect_ctrl_if bus();
  jb_redirect_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_branch"}, bus.cnt_branch, mb);
    chk({tag, "_cnt_taken"}, bus.cnt_taken, mt);
    chk({tag, "_cnt_jump"}, bus.cnt_jump, mj);
  endtask
  task automatic redirect(input logic ev, input logic [4:0] op, input logic br, input logic [31:0] tgt,
                          input int waits, input logic tk, input logic [31:0] pc, input logic trap);
    @(posedge clk); #1;
    bus.ex_valid = ev; bus.ex_opcode = op; bus.ex_br_taken = br; bus.jb_target = tgt; bus.if_ready = 1'b1;
    if (tk) q.push_back('{pc, trap, waits + 1});
    @(negedge clk);
    chk("flush_detect", {30'd0, bus.flush_if, bus.flush_id}, tk ? 32'd3 : 32'd0);
`ifdef JB_PERF_CNT_EN
    if (ev && op == BR) mb++;
    if (ev && op == BR && br) mt++;
    if (ev && (op == JAL || op == JALR)) mj++;
`endif
    if (tk)
      for (int i = 0; i <= waits; i++) begin
        @(posedge clk); #1;
        bus.ex_valid = 1'b1; bus.ex_opcode = JAL; bus.jb_target = 32'h0000_3000; bus.if_ready = (i == waits);
        @(negedge clk);
        chk("flush_pending", {30'd0, bus.flush_if, bus.flush_id}, 32'd3);
      end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0; bus.if_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("idle_after_flush", {30'd0, bus.flush_if, bus.flush_id}, 32'd0);
  endtask
  always @(negedge clk)
    if (!rst_n) active = 1'b0;
    else if (bus.redirect_valid) begin
      if (!active) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_redirect: got redirect_valid=1 pc=%h expected none", bus.redirect_pc);
          cur = '{bus.redirect_pc, 1'b0, 0};
        end else begin
          cur = q.pop_front();
          chk("redirect_pc", bus.redirect_pc, cur.pc);
          chk("trap_first", {31'd0, bus.misalign_trap}, {31'd0, cur.trap});
        end
        active = 1'b1; n = 0;
      end else begin
        chk("pc_stable", bus.redirect_pc, cur.pc);
        chk("trap_single", {31'd0, bus.misalign_trap}, 32'd0);
      end
      n++;
    end else if (active) begin
      active = 1'b0;
      if (cur.len != 0) chk("rv_duration", n, cur.len);
    end
  initial begin
    bus.ex_valid = 1'b0; bus.ex_opcode = '0; bus.ex_br_taken = 1'b0; bus.jb_target = '0; bus.if_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_flush", {30'd0, bus.flush_if, bus.flush_id}, 32'd0);
    chk("rst_trap", {31'd0, bus.misalign_trap}, 32'd0);
    chk("rst_pc", bus.redirect_pc, 32'd0);
    chk_cnt("rst");
    @(posedge clk); #3 rst_n = 1'b1;
    bus.if_ready = 1'b1;
    redirect(1, JAL,  0, 32'h0000_2000, 0, 1, 32'h0000_2000, 0);
    redirect(1, BR,   1, 32'h0000_0040, 3, 1, 32'h0000_0040, 0);
    redirect(1, BR,   0, 32'h0000_0080, 0, 0, 32'h0, 0);
    redirect(1, JALR, 0, 32'h0000_1002, 1, 1, 32'h0000_0100, 1);
    redirect(1, OPR,  1, 32'h0000_0500, 0, 0, 32'h0, 0);
    redirect(1, JAL,  0, 32'h0000_2001, 0, 1, 32'h0000_2001, 0);
    redirect(0, JAL,  0, 32'h0000_4000, 0, 0, 32'h0, 0);
    redirect(1, BR,   1, 32'h0000_0042, 2, 1, 32'h0000_0100, 1);
    chk_cnt("mid");
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_opcode = BR; bus.ex_br_taken = 1'b1; bus.jb_target = 32'h0000_0080; bus.if_ready = 1'b0;
    q.push_back('{32'h0000_0080, 1'b0, 0});
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_wait_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_wait_flush", {30'd0, bus.flush_if, bus.flush_id}, 32'd0);
    chk("rst_wait_pc", bus.redirect_pc, 32'd0);
    mb = '0; mt = '0; mj = '0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk_cnt("post_rst");
`ifdef JB_PERF_CNT_EN
    @(posedge clk); #1;
    force dut.cj_q = 32'hFFFF_FFFF;
    #1 release dut.cj_q;
    mj = 32'hFFFF_FFFF;
`endif
    redirect(1, JAL, 0, 32'h0000_0800, 0, 1, 32'h0000_0800, 0);
    chk_cnt("final");
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
